// File: rtl/led_mode_ctrl_if.sv
// Board-side pin bundle of the LED mode controller: raw key and switches in,
// LEDs and status pulses out.
interface led_mode_ctrl_if #(
  parameter int NB_LED = 8
);
  logic              key_n;
  logic [3:0]        sw;
  logic [NB_LED-1:0] led;
  logic              key_press;
  logic              tick;

  modport master (
    output key_n,
    output sw,
    input  led,
    input  key_press,
    input  tick
  );

  modport slave (
    input  key_n,
    input  sw,
    output led,
    output key_press,
    output tick
  );
endinterface

// File: rtl/led_mode_ctrl.sv
// LED mode controller: synchronises and debounces one push-button and drives
// NB_LED LEDs in mirror, blink, chaser or press-counter mode.
module led_mode_ctrl #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int BLINK_HZ     = 1,
  parameter int NB_LED       = 8,
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic           sys_clk,
  input  logic           sys_rst,
  led_mode_ctrl_if.slave pins
);
  localparam int HALF  = CLK_HZ / (2 * BLINK_HZ);
  localparam int DIV_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int DB_W  = $clog2(DEBOUNCE_CYC);

  localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(HALF - 1);
  localparam logic [DIV_W-1:0]  DIV_ONE    = DIV_W'(1);
  localparam logic [DIV_W-1:0]  DIV_ZERO   = {DIV_W{1'b0}};
  localparam logic [DB_W-1:0]   DB_LAST    = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [DB_W-1:0]   DB_ONE     = DB_W'(1);
  localparam logic [DB_W-1:0]   DB_ZERO    = {DB_W{1'b0}};
  localparam logic [NB_LED-1:0] LED_ZERO   = {NB_LED{1'b0}};
  localparam logic [NB_LED-1:0] LED_ONE    = {{(NB_LED-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    MODE_MIRROR = 2'b00,
    MODE_BLINK  = 2'b01,
    MODE_CHASER = 2'b10,
    MODE_COUNT  = 2'b11
  } mode_e;

  logic              r_key_s1;
  logic              r_key_s2;
  logic [3:0]        r_sw_s1;
  logic [3:0]        r_sw_s2;
  logic              r_key_db;
  logic              r_key_db_d;
  logic [DB_W-1:0]   r_db_cnt;
  logic              r_key_press;
  logic [DIV_W-1:0]  r_div;
  logic              r_tick;
  logic              r_phase;
  logic [NB_LED-1:0] r_chaser;
  logic [NB_LED-1:0] r_press_cnt;
  logic [NB_LED-1:0] r_led;

  mode_e             w_mode;
  logic              w_mode_chg;
  logic [DIV_W-1:0]  w_div_nxt;
  logic [NB_LED-1:0] w_chaser_rot;
  logic [NB_LED-1:0] w_led_live;

  assign w_mode     = mode_e'(r_sw_s2[1:0]);
  assign w_mode_chg = (r_sw_s1[1:0] != r_sw_s2[1:0]);

  // Two-stage synchronisers for the asynchronous key and switches
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_key_s1 <= 1'b1;
      r_key_s2 <= 1'b1;
      r_sw_s1  <= 4'b0000;
      r_sw_s2  <= 4'b0000;
    end else begin
      r_key_s1 <= pins.key_n;
      r_key_s2 <= r_key_s1;
      r_sw_s1  <= pins.sw;
      r_sw_s2  <= r_sw_s1;
    end
  end

  // Debounce: accept the new key level only after DEBOUNCE_CYC differing cycles
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_key_db    <= 1'b1;
      r_key_db_d  <= 1'b1;
      r_db_cnt    <= DB_ZERO;
      r_key_press <= 1'b0;
    end else begin
      r_key_db_d  <= r_key_db;
      r_key_press <= r_key_db_d & ~r_key_db;
      if (r_key_s2 != r_key_db) begin
        if (r_db_cnt == DB_LAST) begin
          r_key_db <= r_key_s2;
          r_db_cnt <= DB_ZERO;
        end else begin
          r_db_cnt <= r_db_cnt + DB_ONE;
        end
      end else begin
        r_db_cnt <= DB_ZERO;
      end
    end
  end

  // Divider next value and chaser rotation candidate
  always_comb begin
    w_div_nxt    = DIV_ZERO;
    w_chaser_rot = r_chaser;
    if (r_div == DIV_LAST) begin
      w_div_nxt = DIV_ZERO;
    end else begin
      w_div_nxt = r_div + DIV_ONE;
    end
    if (r_sw_s2[2]) begin
      w_chaser_rot = {r_chaser[0], r_chaser[NB_LED-1:1]};
    end else begin
      w_chaser_rot = {r_chaser[NB_LED-2:0], r_chaser[NB_LED-1]};
    end
  end

  // r_tick mirrors "divider at HALF-1", so it is registered from the next count
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_div    <= DIV_ZERO;
      r_tick   <= 1'b0;
      r_phase  <= 1'b0;
      r_chaser <= LED_ONE;
    end else begin
      r_div  <= w_div_nxt;
      r_tick <= (w_div_nxt == DIV_LAST);
      if (r_tick) begin
        r_phase <= ~r_phase;
      end
      if (w_mode_chg) begin
        r_chaser <= LED_ONE;
      end else if (r_tick) begin
        r_chaser <= w_chaser_rot;
      end
    end
  end

  // Press counter, wraps naturally at all-ones
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_press_cnt <= LED_ZERO;
    end else if (r_key_press) begin
      r_press_cnt <= r_press_cnt + LED_ONE;
    end
  end

  // Live LED pattern for the current mode
  always_comb begin
    w_led_live = LED_ZERO;
    case (w_mode)
      MODE_MIRROR: w_led_live = {{(NB_LED-1){1'b0}}, ~r_key_db};
      MODE_BLINK:  w_led_live = {NB_LED{r_phase}};
      MODE_CHASER: w_led_live = r_chaser;
      MODE_COUNT:  w_led_live = r_press_cnt;
      default:     w_led_live = LED_ZERO;
    endcase
  end

  // LED register; freeze simply stops the load
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_led <= LED_ZERO;
    end else if (!r_sw_s2[3]) begin
      r_led <= w_led_live;
    end
  end

  assign pins.led       = r_led;
  assign pins.key_press = r_key_press;
  assign pins.tick      = r_tick;
endmodule

// File: tb/tb_led_mode_ctrl.sv
// Bench for led_mode_ctrl: directed scenarios plus random key/switch traffic,
// checked through a scoreboard fed by a behavioural model of the controller.
module tb_led_mode_ctrl;
  localparam int HALF = 10;
  localparam int DEB  = 4;
  localparam int NB   = 8;

  typedef struct packed {
    logic [7:0] led;
    logic       kp;
    logic       tick;
  } exp_t;

  logic sys_clk;
  logic sys_rst;
  int   n_checks;
  int   n_fail;
  exp_t sb_q[$];

  // behavioural model state
  logic       m_k1, m_k2, m_kdb, m_kdb_prev, m_kp, m_phase;
  logic [3:0] m_s1, m_s2;
  logic [7:0] m_led;
  int         m_run, m_div, m_pos, m_cnt;

  led_mode_ctrl_if #(.NB_LED(NB)) pins ();

  led_mode_ctrl #(
    .CLK_HZ      (1000),
    .BLINK_HZ    (50),
    .NB_LED      (NB),
    .DEBOUNCE_CYC(DEB)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .pins   (pins)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One rising edge of the reference: every next value derived from pre-edge state
  task automatic model_edge();
    logic [7:0] n_led;
    logic       n_kdb, n_kp, n_phase;
    int         n_run, n_pos, n_cnt;
    if (sys_rst) begin
      m_k1 = 1'b1; m_k2 = 1'b1; m_s1 = 4'h0; m_s2 = 4'h0;
      m_kdb = 1'b1; m_kdb_prev = 1'b1; m_run = 0; m_kp = 1'b0;
      m_div = 0; m_phase = 1'b0; m_pos = 0; m_cnt = 0; m_led = 8'h00;
    end else begin
      n_led = m_led;
      if (!m_s2[3]) begin
        case (m_s2[1:0])
          2'd0:    n_led = {7'd0, ~m_kdb};
          2'd1:    n_led = m_phase ? 8'hFF : 8'h00;
          2'd2:    n_led = 8'(1 << m_pos);
          default: n_led = 8'(m_cnt);
        endcase
      end
      n_cnt = (m_cnt + (m_kp ? 1 : 0)) % 256;
      n_kp  = m_kdb_prev & ~m_kdb;
      n_kdb = m_kdb;
      n_run = 0;
      if (m_k2 != m_kdb) begin
        if (m_run + 1 >= DEB) n_kdb = m_k2;
        else n_run = m_run + 1;
      end
      if (m_s1[1:0] != m_s2[1:0]) n_pos = 0;
      else if (m_div == HALF - 1) n_pos = m_s2[2] ? (m_pos + NB - 1) % NB : (m_pos + 1) % NB;
      else n_pos = m_pos;
      n_phase = (m_div == HALF - 1) ? ~m_phase : m_phase;
      m_kdb_prev = m_kdb;
      m_kdb = n_kdb; m_run = n_run; m_kp = n_kp; m_cnt = n_cnt;
      m_pos = n_pos; m_phase = n_phase; m_led = n_led;
      m_div = (m_div + 1) % HALF;
      m_k2 = m_k1; m_k1 = pins.key_n;
      m_s2 = m_s1; m_s1 = pins.sw;
    end
    sb_q.push_back(exp_t'{led: m_led, kp: m_kp, tick: (m_div == HALF - 1)});
  endtask

  task automatic cyc();
    @(posedge sys_clk);
    model_edge();
    @(negedge sys_clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic press();
    pins.key_n = 1'b0;
    run(7);
    pins.key_n = 1'b1;
    run(7);
  endtask

  // Monitor: the DUT presents a fresh output set every cycle
  always @(negedge sys_clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("led", 32'(pins.led), 32'(e.led));
      chk("key_press", 32'(pins.key_press), 32'(e.kp));
      chk("tick", 32'(pins.tick), 32'(e.tick));
    end
  end

  initial begin
    int first;
    n_checks = 0;
    n_fail   = 0;
    sys_rst    = 1'b1;
    pins.key_n = 1'b0;
    pins.sw    = 4'b0001;
    @(negedge sys_clk);

    // reset held with key pressed and blink selected
    run(3);
    chk("reset_led", 32'(pins.led), 32'h0);
    sys_rst    = 1'b0;
    pins.key_n = 1'b1;
    run(12);

    // mirror: short glitch rejected, long press accepted after 7 edges
    pins.sw = 4'b0000;
    run(4);
    pins.key_n = 1'b0;
    run(3);
    pins.key_n = 1'b1;
    run(10);
    pins.key_n = 1'b0;
    first = 0;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      if (first == 0 && pins.led[0] === 1'b1) first = i;
    end
    chk("mirror_latency", 32'(first), 32'd7);
    pins.key_n = 1'b1;
    run(12);

    // blink, then chaser both directions
    pins.sw = 4'b0001;
    run(45);
    pins.sw = 4'b0010;
    run(90);
    pins.sw = 4'b0110;
    run(30);

    // count: fresh reset, 3 presses, then wrap after 256
    sys_rst = 1'b1;
    pins.sw = 4'b0011;
    run(2);
    sys_rst = 1'b0;
    run(4);
    for (int i = 0; i < 3; i++) press();
    run(3);
    chk("count_3", 32'(pins.led), 32'h03);
    for (int i = 3; i < 256; i++) press();
    run(3);
    chk("count_wrap", 32'(pins.led), 32'h00);

    // chaser, freeze, unfreeze, then reset mid-debounce
    pins.sw = 4'b0010;
    run(25);
    pins.sw = 4'b1010;
    run(30);
    pins.sw = 4'b0010;
    run(15);
    pins.key_n = 1'b0;
    run(4);
    pins.key_n = 1'b1;
    sys_rst    = 1'b1;
    cyc();
    chk("rst_mid_led", 32'(pins.led), 32'h0);
    chk("rst_mid_kp", 32'(pins.key_press), 32'h0);
    sys_rst = 1'b0;
    run(30);

    // random traffic, including glitches, mode changes and occasional reset
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 39) == 0) pins.sw = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0) pins.key_n = ~pins.key_n;
      sys_rst = ($urandom_range(0, 149) == 0);
      cyc();
    end
    sys_rst = 1'b0;
    run(5);

    repeat (2) @(negedge sys_clk);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
